// File: rtl/nnet_ctrl_pkg.sv
// Shared types and control-word layout for the nnet inference controller.
package nnet_ctrl_pkg;

  localparam int CTRL_W       = 2;
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FEED,
    ST_PAD,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/nnet_inference_ctrl_if.sv
// AXI-stream style beat channel used for the wrapper and HLS data/result ports.
interface nnet_inference_ctrl_if #(parameter int DATA_W = 32);

  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/nnet_inference_ctrl.sv
// Frame controller between the wrapper streams and an HLS ap_ctrl_hs core.
// Optional latency counter: define NNET_CTRL_PERF_CNT_EN to add lat_cycles.
module nnet_inference_ctrl
  import nnet_ctrl_pkg::*;
#(
  parameter int SR_CTRL = 132,
  parameter int CNT_W   = 16
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [CNT_W-1:0] size_in,
  input  logic [CNT_W-1:0] size_out,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  nnet_inference_ctrl_if.slave  s,
  nnet_inference_ctrl_if.master m,
  nnet_inference_ctrl_if.slave  r,
  nnet_inference_ctrl_if.master o,
  output logic             busy,
  output logic             err_short,
  output logic             err_long,
  output logic [31:0]      frame_cnt
`ifdef NNET_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]      lat_cycles
`endif
);

  localparam logic [7:0] SR_ADDR = 8'(SR_CTRL);

  state_t            state_reg, state_next;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [CNT_W-1:0]  in_cnt_reg, in_cnt_next;
  logic [CNT_W-1:0]  out_cnt_reg, out_cnt_next;
  logic [CNT_W-1:0]  size_in_reg, size_out_reg;
  logic              done_seen_reg;
  logic              err_short_reg, err_long_reg;
  logic [31:0]       frame_cnt_reg;

  logic ctrl_wr, err_clr, last_in;
  logic start_frame, frame_done, set_short, set_long;

  assign ctrl_wr = set_stb && (set_addr == SR_ADDR);
  // The clear bit lives one cycle in ctrl_reg; a same-cycle error event still sets.
  assign err_clr = ctrl_reg[CTRL_CLR_BIT];
  assign last_in = (in_cnt_reg == size_in_reg - CNT_W'(1));

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      ctrl_reg <= '0;
    end else if (ctrl_wr) begin
      ctrl_reg <= set_data[CTRL_W-1:0];
    end else begin
      ctrl_reg[CTRL_CLR_BIT] <= 1'b0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    in_cnt_next  = in_cnt_reg;
    out_cnt_next = out_cnt_reg;
    start_frame  = 1'b0;
    frame_done   = 1'b0;
    set_short    = 1'b0;
    set_long     = 1'b0;
    ap_start     = 1'b0;
    s.tready     = 1'b0;
    m.tvalid     = 1'b0;
    m.tdata      = '0;
    m.tlast      = 1'b0;
    r.tready     = 1'b0;
    o.tvalid     = 1'b0;
    o.tdata      = '0;
    o.tlast      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (ctrl_reg[CTRL_EN_BIT] && s.tvalid && ap_idle &&
            (size_in != '0) && (size_out != '0)) begin
          state_next   = ST_START;
          start_frame  = 1'b1;
          in_cnt_next  = '0;
          out_cnt_next = '0;
        end
      end
      ST_START: begin
        ap_start = 1'b1;
        if (ap_ready) state_next = ST_FEED;
      end
      ST_FEED: begin
        m.tvalid = s.tvalid;
        m.tdata  = s.tdata;
        m.tlast  = last_in;
        s.tready = m.tready;
        if (s.tvalid && m.tready) begin
          in_cnt_next = in_cnt_reg + CNT_W'(1);
          if (s.tlast && !last_in) begin
            set_short  = 1'b1;
            state_next = ST_PAD;
          end else if (last_in) begin
            if (s.tlast) begin
              state_next = ST_DRAIN;
            end else begin
              set_long   = 1'b1;
              state_next = ST_FLUSH;
            end
          end
        end
      end
      ST_PAD: begin
        m.tvalid = 1'b1;
        m.tlast  = last_in;
        if (m.tready) begin
          in_cnt_next = in_cnt_reg + CNT_W'(1);
          if (last_in) state_next = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        s.tready = 1'b1;
        if (s.tvalid && s.tlast) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((out_cnt_reg == size_out_reg) && (done_seen_reg || ap_done)) begin
          state_next = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Result path runs independently of the input side for the whole frame.
    if (state_reg != ST_IDLE) begin
      if (out_cnt_reg != size_out_reg) begin
        o.tvalid = r.tvalid;
        o.tdata  = r.tdata;
        o.tlast  = (out_cnt_reg == size_out_reg - CNT_W'(1));
        r.tready = o.tready;
        if (r.tvalid && o.tready) out_cnt_next = out_cnt_reg + CNT_W'(1);
      end else begin
        r.tready = 1'b1;
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst || clear) begin
      state_reg     <= ST_IDLE;
      in_cnt_reg    <= '0;
      out_cnt_reg   <= '0;
      size_in_reg   <= '0;
      size_out_reg  <= '0;
      done_seen_reg <= 1'b0;
      err_short_reg <= 1'b0;
      err_long_reg  <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      in_cnt_reg    <= in_cnt_next;
      out_cnt_reg   <= out_cnt_next;
      err_short_reg <= set_short | (err_short_reg & ~err_clr);
      err_long_reg  <= set_long | (err_long_reg & ~err_clr);
      if (start_frame) begin
        size_in_reg   <= size_in;
        size_out_reg  <= size_out;
        done_seen_reg <= 1'b0;
      end else if ((state_reg != ST_IDLE) && ap_done) begin
        done_seen_reg <= 1'b1;
      end
      if (frame_done) frame_cnt_reg <= frame_cnt_reg + 32'd1;
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign err_short = err_short_reg;
  assign err_long  = err_long_reg;
  assign frame_cnt = frame_cnt_reg;

`ifdef NNET_CTRL_PERF_CNT_EN
  logic [31:0] lat_run_reg, lat_cycles_reg;

  always_ff @(posedge ce_clk) begin
    if (ce_rst || clear) begin
      lat_run_reg    <= '0;
      lat_cycles_reg <= '0;
    end else begin
      if (start_frame) lat_run_reg <= '0;
      else if (busy)   lat_run_reg <= lat_run_reg + 32'd1;
      if (frame_done)  lat_cycles_reg <= lat_run_reg + 32'd1;
    end
  end

  assign lat_cycles = lat_cycles_reg;
`endif

endmodule

// File: tb/tb_nnet_inference_ctrl.sv
// Self-checking bench: vector table, random frames and reset/enable corner sequences.
`timescale 1ns/1ps
module tb_nnet_inference_ctrl;

  localparam int CNT_W   = 16;
  localparam int SR_CTRL = 132;

  logic             ce_clk = 1'b0;
  logic             ce_rst = 1'b1;
  logic             clear = 1'b0;
  logic             set_stb = 1'b0;
  logic [7:0]       set_addr = '0;
  logic [31:0]      set_data = '0;
  logic [CNT_W-1:0] size_in = '0;
  logic [CNT_W-1:0] size_out = '0;
  logic             ap_start;
  logic             ap_ready = 1'b0;
  logic             ap_done = 1'b0;
  logic             ap_idle = 1'b1;
  logic             busy, err_short, err_long;
  logic [31:0]      frame_cnt;

  nnet_inference_ctrl_if s_if ();
  nnet_inference_ctrl_if m_if ();
  nnet_inference_ctrl_if r_if ();
  nnet_inference_ctrl_if o_if ();

  nnet_inference_ctrl #(.SR_CTRL(SR_CTRL), .CNT_W(CNT_W)) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .size_in(size_in), .size_out(size_out),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .s(s_if), .m(m_if), .r(r_if), .o(o_if),
    .busy(busy), .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt)
  );

  always #5 ce_clk = ~ce_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;
  bit exp_es = 1'b0, exp_el = 1'b0;
  bit hold_o = 1'b0;

  logic [31:0] m_got[$];
  logic [32:0] o_got[$];
  logic [31:0] s_sent[$];
  logic [31:0] r_sent[$];

  typedef struct {
    int n; int si; int so; int nr; int special;
    bit exp_short; bit exp_long;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s: got no event expected event", name);
  endtask

  // Handshake monitor: values seen at negedge are the ones taken at the next posedge.
  always @(negedge ce_clk) begin
    if (!ce_rst) begin
      if (m_if.tvalid && m_if.tready) m_got.push_back(m_if.tdata);
      if (o_if.tvalid && o_if.tready) o_got.push_back({o_if.tlast, o_if.tdata});
    end
  end

  always @(posedge ce_clk) begin
    #1;
    m_if.tready = ($urandom_range(0, 3) != 0);
    o_if.tready = hold_o ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic write_ctrl(input logic [31:0] d);
    @(posedge ce_clk); #1;
    set_stb = 1'b1; set_addr = 8'(SR_CTRL); set_data = d;
    @(posedge ce_clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic drive_s(input int n);
    logic [31:0] d;
    int t;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge ce_clk); #1;
      end
      d = $urandom;
      s_if.tdata = d; s_if.tlast = (i == n - 1); s_if.tvalid = 1'b1;
      t = 0;
      @(negedge ce_clk);
      while (!s_if.tready && t < 300) begin @(negedge ce_clk); t++; end
      if (!s_if.tready) begin timeout_fail("s_beat"); break; end
      s_sent.push_back(d);
      @(posedge ce_clk); #1;
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
  endtask

  // HLS core model: handshake start, consume si data beats, emit nr results, pulse done.
  task automatic hls_run(input int si, input int nr);
    int t, d;
    bit ok;
    logic [31:0] v;
    t = 0;
    @(negedge ce_clk);
    while (!ap_start && t < 300) begin @(negedge ce_clk); t++; end
    if (!ap_start) begin timeout_fail("ap_start"); return; end
    d = $urandom_range(0, 3);
    ok = 1'b1;
    repeat (d) begin @(negedge ce_clk); if (!ap_start) ok = 1'b0; end
    check("ap_start_hold", ok, 1);
    @(posedge ce_clk); #1; ap_ready = 1'b1; ap_idle = 1'b0;
    @(posedge ce_clk); #1; ap_ready = 1'b0;
    @(negedge ce_clk);
    check("ap_start_drop", ap_start, 0);
    t = 0;
    while (m_got.size() < si && t < 600) begin @(negedge ce_clk); t++; end
    if (m_got.size() < si) timeout_fail("m_beats");
    for (int i = 0; i < nr; i++) begin
      @(posedge ce_clk); #1;
      v = $urandom;
      r_if.tdata = v; r_if.tvalid = 1'b1;
      t = 0;
      @(negedge ce_clk);
      while (!r_if.tready && t < 300) begin @(negedge ce_clk); t++; end
      if (!r_if.tready) begin timeout_fail("r_beat"); break; end
      r_sent.push_back(v);
    end
    @(posedge ce_clk); #1; r_if.tvalid = 1'b0; ap_done = 1'b1;
    @(posedge ce_clk); #1; ap_done = 1'b0; ap_idle = 1'b1;
  endtask

  task automatic o_hold();
    int t, cnt;
    bit ok;
    t = 0;
    while (o_got.size() < 1 && t < 600) begin @(negedge ce_clk); t++; end
    if (o_got.size() < 1) begin timeout_fail("o_first"); return; end
    hold_o = 1'b1;
    @(negedge ce_clk);
    cnt = o_got.size();
    ok = 1'b1;
    repeat (10) begin @(negedge ce_clk); if (!busy) ok = 1'b0; end
    check("hold_busy", ok, 1);
    check("hold_no_beat", o_got.size(), cnt);
    hold_o = 1'b0;
  endtask

  task automatic disable_mid();
    int t;
    t = 0;
    while (m_got.size() < 1 && t < 600) begin @(negedge ce_clk); t++; end
    if (m_got.size() < 1) begin timeout_fail("m_first"); return; end
    write_ctrl(32'd0);
  endtask

  task automatic run_frame(input int n, input int si, input int so, input int nr,
                           input bit wr_ctrl, input int special);
    int t;
    logic [31:0] em;
    logic [32:0] eo;
    m_got.delete(); o_got.delete(); s_sent.delete(); r_sent.delete();
    size_in = CNT_W'(si); size_out = CNT_W'(so);
    if (wr_ctrl) begin
      write_ctrl(32'd3);
      exp_es = 1'b0; exp_el = 1'b0;
    end
    fork
      drive_s(n);
      hls_run(si, nr);
      if (special == 1) o_hold();
      else if (special == 2) disable_mid();
    join
    t = 0;
    @(negedge ce_clk);
    while (busy && t < 300) begin @(negedge ce_clk); t++; end
    if (busy) timeout_fail("frame_end");
    exp_frames++;
    exp_es = exp_es | (n < si);
    exp_el = exp_el | (n > si);
    // Data seen by HLS: the first si input beats, zero-padded if the frame was short.
    check("m_count", m_got.size(), si);
    for (int i = 0; i < si && i < m_got.size(); i++) begin
      em = (i < n && i < s_sent.size()) ? s_sent[i] : 32'd0;
      check($sformatf("m_beat%0d", i), m_got[i], em);
    end
    check("o_count", o_got.size(), so);
    for (int i = 0; i < so && i < o_got.size() && i < r_sent.size(); i++) begin
      eo = {(i == so - 1) ? 1'b1 : 1'b0, r_sent[i]};
      check($sformatf("o_beat%0d", i), o_got[i], eo);
    end
    check("err_short", err_short, exp_es);
    check("err_long", err_long, exp_el);
    check("frame_cnt", frame_cnt, exp_frames);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, si, so, nr;
    bit ok;
    s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
    r_if.tdata = '0; r_if.tlast = 1'b0; r_if.tvalid = 1'b0;
    m_if.tready = 1'b0; o_if.tready = 1'b0;

    vecs[0] = '{n: 4, si: 4, so: 2, nr: 2, special: 0, exp_short: 0, exp_long: 0};
    vecs[1] = '{n: 2, si: 4, so: 2, nr: 2, special: 0, exp_short: 1, exp_long: 0};
    vecs[2] = '{n: 6, si: 4, so: 2, nr: 3, special: 0, exp_short: 0, exp_long: 1};
    vecs[3] = '{n: 1, si: 1, so: 1, nr: 1, special: 0, exp_short: 0, exp_long: 0};
    vecs[4] = '{n: 3, si: 5, so: 4, nr: 4, special: 1, exp_short: 1, exp_long: 0};
    vecs[5] = '{n: 5, si: 3, so: 3, nr: 5, special: 0, exp_short: 0, exp_long: 1};

    repeat (3) @(posedge ce_clk);
    #1 ce_rst = 1'b0;
    @(negedge ce_clk);
    check("rst_busy", busy, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_o_tvalid", o_if.tvalid, 0);
    check("rst_r_tready", r_if.tready, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", {err_short, err_long}, 0);

    foreach (vecs[k]) begin
      run_frame(vecs[k].n, vecs[k].si, vecs[k].so, vecs[k].nr, 1'b1, vecs[k].special);
      check($sformatf("vec%0d_short", k), err_short, vecs[k].exp_short);
      check($sformatf("vec%0d_long", k), err_long, vecs[k].exp_long);
      $display("vector %0d: n=%0d size_in=%0d size_out=%0d frame_cnt=%0d", k,
               vecs[k].n, vecs[k].si, vecs[k].so, frame_cnt);
    end

    for (int k = 0; k < 8; k++) begin
      n  = $urandom_range(1, 7);
      si = $urandom_range(1, 6);
      so = $urandom_range(1, 4);
      nr = so + $urandom_range(0, 2);
      run_frame(n, si, so, nr, 1'b1, 0);
      $display("random %0d: n=%0d size_in=%0d size_out=%0d frame_cnt=%0d", k, n, si, so, frame_cnt);
    end

    // Soft clear keeps the enable bit: the next frame runs without a ctrl write.
    @(posedge ce_clk); #1 clear = 1'b1;
    @(posedge ce_clk); #1 clear = 1'b0;
    @(negedge ce_clk);
    check("clr_frame_cnt", frame_cnt, 0);
    exp_frames = 0; exp_es = 1'b0; exp_el = 1'b0;
    run_frame(3, 3, 2, 2, 1'b0, 0);
    $display("clear: frame_cnt=%0d", frame_cnt);

    // Enable dropped mid-frame: frame finishes, then input is ignored.
    run_frame(4, 4, 2, 2, 1'b1, 2);
    s_if.tvalid = 1'b1; s_if.tlast = 1'b1;
    ok = 1'b1;
    repeat (20) begin @(negedge ce_clk); if (s_if.tready || busy) ok = 1'b0; end
    check("disabled_idle", ok, 1);
    check("disabled_frame_cnt", frame_cnt, exp_frames);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    $display("disable: frame_cnt=%0d", frame_cnt);

    // Reset while stuck in DRAIN (fewer results than size_out).
    m_got.delete(); o_got.delete(); s_sent.delete(); r_sent.delete();
    size_in = CNT_W'(2); size_out = CNT_W'(3);
    write_ctrl(32'd3);
    fork
      drive_s(2);
      hls_run(2, 1);
    join
    repeat (3) @(negedge ce_clk);
    check("drain_busy", busy, 1);
    @(posedge ce_clk); #1 ce_rst = 1'b1;
    @(posedge ce_clk); #1 ce_rst = 1'b0;
    @(negedge ce_clk);
    check("drain_rst_outs", {busy, ap_start, m_if.tvalid, o_if.tvalid, o_if.tlast,
                             s_if.tready, r_if.tready, err_short, err_long}, 0);
    check("drain_rst_frame_cnt", frame_cnt, 0);
    s_if.tvalid = 1'b1;
    ok = 1'b1;
    repeat (10) begin @(negedge ce_clk); if (busy || s_if.tready) ok = 1'b0; end
    check("rst_ctrl_cleared", ok, 1);
    s_if.tvalid = 1'b0;
    exp_frames = 0;
    run_frame(4, 4, 2, 2, 1'b1, 0);
    $display("reset in drain: restart frame_cnt=%0d", frame_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
